spike_event_encoder: RTL

SPIKE_EVENT_ENCODER -- requirements
Module: spike_event_encoder

---
 rtl/spike_enc_pkg.sv | 12 +
 rtl/event_fifo.sv | 56 +++++
 rtl/spike_event_encoder.sv | 95 +++++++++
 3 files changed

// File: rtl/spike_enc_pkg.sv
// Shared types and constants for the spike event encoder: FSM states, ISI width/saturation, default thresholds.
package spike_enc_pkg;
    typedef enum logic {
        ST_ARMED = 1'b0,
        ST_FIRED = 1'b1
    } enc_state_t;

    localparam int                ISI_W     = 16;
    localparam logic [ISI_W-1:0]  ISI_SAT   = 16'hFFFF;
    localparam logic signed [7:0] TH_HI_DEF = 8'sd32;
    localparam logic signed [7:0] TH_LO_DEF = -8'sd16;
endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with simultaneous push/pop; output visible one cycle after push, reads 0 when empty.
// A push into a full FIFO is refused unless a pop frees the entry on the same edge.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_dat   = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end
endmodule

// File: rtl/spike_event_encoder.sv
// Hysteretic spike detector producing ISI event words into a FIFO plus a windowed spike rate.
// Spike pulse 1 cycle after detection; events wait in the FIFO under ev_ready backpressure, dropped (sticky overflow) when full.
module spike_event_encoder
    import spike_enc_pkg::*;
#(
    parameter logic signed [7:0] TH_HI      = TH_HI_DEF,
    parameter logic signed [7:0] TH_LO      = TH_LO_DEF,
    parameter int                FIFO_DEPTH = 4,
    parameter int                WIN_LOG2   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  v_in,
    output logic        spike_pulse,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [15:0] ev_data,
    output logic [7:0]  rate_out,
    output logic        overflow,
    input  logic        ovf_clr
);
    enc_state_t          r_state;
    logic [ISI_W-1:0]    r_isi;
    logic [WIN_LOG2-1:0] r_win;
    logic [7:0]          r_spk_cnt;

    logic             w_above;
    logic             w_below;
    logic             w_detect;
    logic             w_wrap;
    logic             w_drop;
    logic             w_empty;
    logic             w_full;
    logic [ISI_W-1:0] w_ev_word;
    logic [7:0]       w_spk_next;

    assign w_above    = $signed(v_in) > TH_HI;
    assign w_below    = $signed(v_in) < TH_LO;
    assign w_detect   = ena && (r_state == ST_ARMED) && w_above;
    assign w_ev_word  = (r_isi == ISI_SAT) ? ISI_SAT : r_isi + 1'b1;
    assign w_wrap     = ena && (r_win == {WIN_LOG2{1'b1}});
    assign w_spk_next = (w_detect && r_spk_cnt != 8'hFF) ? r_spk_cnt + 8'd1 : r_spk_cnt;
    // A same-edge pop makes room, so only a push with no pop into a full FIFO is lost.
    assign w_drop     = w_detect && w_full && !(ev_ready && !w_empty);
    assign ev_valid   = !w_empty;

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ISI_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_detect),
        .i_dat   (w_ev_word),
        .i_pop   (ev_ready),
        .o_dat   (ev_data),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_ARMED;
            r_isi       <= '0;
            r_win       <= '0;
            r_spk_cnt   <= '0;
            spike_pulse <= 1'b0;
            rate_out    <= '0;
            overflow    <= 1'b0;
        end else begin
            spike_pulse <= w_detect;
            if (ena) begin
                if (r_state == ST_ARMED) begin
                    if (w_above) r_state <= ST_FIRED;
                end else begin
                    if (w_below) r_state <= ST_ARMED;
                end
                r_isi <= w_detect ? '0 : w_ev_word;
                r_win <= r_win + 1'b1;
                if (w_wrap) begin
                    rate_out  <= w_spk_next;
                    r_spk_cnt <= '0;
                end else begin
                    r_spk_cnt <= w_spk_next;
                end
            end
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule
